// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit signed shift-add multiplier.
// Holds the datapath width, the command encoding and the sign-extension helper.
package mult_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        CLR_LD = 3'd1,
        ADD    = 3'd2,
        SUB    = 3'd3,
        SHIFT  = 3'd4
    } dp_cmd_t;

    function automatic logic signed [WIDTH:0] sext9(input logic signed [WIDTH-1:0] v);
        return {v[WIDTH-1], v};
    endfunction

endpackage

// File: rtl/mult_datapath_add_sub9.sv
// 9-bit ripple-carry adder/subtractor built from full-adder cells.
// Subtraction is A9 + ~S9 + 1: the sub input inverts S9 and seeds the carry.
module add_sub9
    import mult_pkg::*;
(
    input  logic signed [WIDTH:0] A9,
    input  logic signed [WIDTH:0] S9,
    input  logic                  sub,
    output logic signed [WIDTH:0] sum
);

    logic [WIDTH+1:0] carry;
    logic [WIDTH:0]   b_in;

    assign carry[0] = sub;
    assign b_in     = S9 ^ {(WIDTH+1){sub}};

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign sum[i]     = A9[i] ^ b_in[i] ^ carry[i];
        assign carry[i+1] = (A9[i] & b_in[i]) | (A9[i] & carry[i]) | (b_in[i] & carry[i]);
    end

    // Carry out of bit 8 is discarded: the result is taken modulo 2^9.
    logic unused_carry;
    assign unused_carry = carry[WIDTH+1];

endmodule

// File: rtl/mult_datapath.sv
// Register datapath of the signed shift-add multiplier: X, A and B registers
// updated by one prioritised command per clock from the control unit.
module mult_datapath
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] S,
    input  logic             clr_ld,
    input  logic             add,
    input  logic             sub,
    input  logic             shift,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             M
);

    dp_cmd_t                 cmd;
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic                    x_q;
    logic signed [WIDTH-1:0] a_d;
    logic signed [WIDTH-1:0] b_d;
    logic                    x_d;
    logic signed [WIDTH:0]   sum9;

    always_comb begin
        cmd = NONE;
        if (clr_ld)     cmd = CLR_LD;
        else if (sub)   cmd = SUB;
        else if (add)   cmd = ADD;
        else if (shift) cmd = SHIFT;
    end

    add_sub9 u_add_sub9 (
        .A9  (sext9(a_q)),
        .S9  (sext9(S)),
        .sub (cmd == SUB),
        .sum (sum9)
    );

    // X is overwritten by the adder's ninth bit, absorbing 8-bit overflow.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        case (cmd)
            CLR_LD: begin
                a_d = '0;
                x_d = 1'b0;
                b_d = S;
            end
            ADD, SUB: begin
                x_d = sum9[WIDTH];
                a_d = sum9[WIDTH-1:0];
            end
            SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign M    = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath with hand-computed expectations.
module tb_mult_datapath;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] S = 8'h00;
    logic       clr_ld = 1'b0;
    logic       add = 1'b0;
    logic       sub = 1'b0;
    logic       shift = 1'b0;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       M;

    int checks = 0;
    int errors = 0;

    mult_datapath dut (
        .Clk    (Clk),
        .reset  (reset),
        .S      (S),
        .clr_ld (clr_ld),
        .add    (add),
        .sub    (sub),
        .shift  (shift),
        .Aval   (Aval),
        .Bval   (Bval),
        .X      (X),
        .M      (M)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic x_e, input logic [7:0] a_e,
                               input logic [7:0] b_e);
        check({tag, ".X"}, {31'd0, X}, {31'd0, x_e});
        check({tag, ".A"}, {24'd0, Aval}, {24'd0, a_e});
        check({tag, ".B"}, {24'd0, Bval}, {24'd0, b_e});
        check({tag, ".M"}, {31'd0, M}, {31'd0, b_e[0]});
    endtask

    // Apply one set of command lines for exactly one rising edge.
    task automatic step(input logic c, input logic a, input logic s, input logic sh,
                        input logic [7:0] sv);
        @(negedge Clk);
        clr_ld = c;
        add    = a;
        sub    = s;
        shift  = sh;
        S      = sv;
        @(posedge Clk);
        #1;
        clr_ld = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        shift  = 1'b0;
    endtask

    // Scripted multiply: add (or sub on the MSB) when the multiplier bit is set, then shift.
    task automatic multiply(input string tag, input logic [7:0] mplier, input logic [7:0] mcand,
                            input logic [7:0] a_e, input logic [7:0] b_e);
        logic [7:0] bits;
        bits = mplier;
        step(1'b1, 1'b0, 1'b0, 1'b0, mplier);
        for (int i = 0; i < 8; i++) begin
            if (bits[i]) begin
                if (i == 7) step(1'b0, 1'b0, 1'b1, 1'b0, mcand);
                else        step(1'b0, 1'b1, 1'b0, 1'b0, mcand);
            end
            step(1'b0, 1'b0, 1'b0, 1'b1, mcand);
        end
        check({tag, ".A"}, {24'd0, Aval}, {24'd0, a_e});
        check({tag, ".B"}, {24'd0, Bval}, {24'd0, b_e});
    endtask

    initial begin
        #12;
        check_state("reset_init", 1'b0, 8'h00, 8'h00);
        @(negedge Clk);
        reset = 1'b1;

        // Build A=0x5A, B=0x33 then reset asynchronously between edges.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
        check_state("preload", 1'b0, 8'h5A, 8'h33);
        #2;
        reset = 1'b0;
        #1;
        check_state("async_reset", 1'b0, 8'h00, 8'h00);
        @(negedge Clk);
        reset = 1'b1;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        check_state("clr_ld_07", 1'b0, 8'h00, 8'h07);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFD);
        check_state("add_FD", 1'b1, 8'hFD, 8'h07);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_state("shift", 1'b1, 8'hFE, 8'h83);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
        check_state("hold", 1'b1, 8'hFE, 8'h83);

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
        check_state("sub_02", 1'b1, 8'hFE, 8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        check_state("sub_80", 1'b0, 8'h7E, 8'h00);

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h7F);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        check_state("add_ovf", 1'b0, 8'h80, 8'h00);

        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h11);
        check_state("prio_clr", 1'b0, 8'h00, 8'h11);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h01);
        check_state("prio_sub", 1'b1, 8'hFF, 8'h11);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
        check_state("prio_add", 1'b0, 8'h00, 8'h11);

        multiply("mul_m7_m3", 8'hF9, 8'hFD, 8'h00, 8'h15);
        multiply("mul_80_80", 8'h80, 8'h80, 8'h40, 8'h00);
        multiply("mul_05_m6", 8'h05, 8'hFA, 8'hFF, 8'hE2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
